// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the decoded-entry layout held by the ID/EX buffer.
package rv32i_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;

  // funct3 value that selects the shift-right group in OP-IMM (SRLI/SRAI)
  localparam logic [2:0] F3ShiftRight = 3'b101;

  // One decoded instruction, as stored in the main and skid registers
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        func7;
    logic [2:0]  funct3;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [2:0]  mem_funct3;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/id_ex_decode.sv
// Combinational operand/immediate selection for one raw instruction.
module id_ex_decode
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output entry_t      entry
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Select ALU operands and the immediate by opcode; unknown opcodes flag illegal
  always_comb begin
    entry            = '0;
    entry.op         = opcode;
    entry.pc         = pc;
    entry.rs2_val    = rs2_val;
    entry.rd         = instr[11:7];
    entry.mem_funct3 = funct3;
    case (opcode)
      OpcOp: begin
        entry.a      = rs1_val;
        entry.b      = rs2_val;
        entry.func7  = instr[30];
        entry.funct3 = funct3;
      end
      OpcOpImm: begin
        entry.a      = rs1_val;
        entry.b      = imm_i;
        // instr[30] is only an opcode modifier for SRLI/SRAI; elsewhere it is immediate data
        entry.func7  = (funct3 == F3ShiftRight) ? instr[30] : 1'b0;
        entry.funct3 = funct3;
        entry.imm    = imm_i;
      end
      OpcBranch: begin
        entry.a      = rs1_val;
        entry.b      = rs2_val;
        entry.funct3 = funct3;
        entry.imm    = imm_b;
      end
      OpcLui: begin
        entry.b   = imm_u;
        entry.imm = imm_u;
      end
      OpcAuipc: begin
        entry.a   = pc;
        entry.b   = imm_u;
        entry.imm = imm_u;
      end
      OpcJal: begin
        entry.a   = pc;
        entry.b   = 32'd4;
        entry.imm = imm_j;
      end
      OpcJalr: begin
        entry.a   = pc;
        entry.b   = 32'd4;
        entry.imm = imm_i;
      end
      OpcLoad: begin
        entry.a   = rs1_val;
        entry.b   = imm_i;
        entry.imm = imm_i;
      end
      OpcStore: begin
        entry.a   = rs1_val;
        entry.b   = imm_s;
        entry.imm = imm_s;
      end
      default: begin
        entry.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes on the input side and holds results in a 2-entry skid buffer.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_func7,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_op,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_mem_funct3,
  output logic            out_illegal
);

  entry_t dec_entry;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;
  logic   fire;

  id_ex_decode u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .entry   (dec_entry)
  );

  // Ready depends only on skid occupancy, so there is no path from out_ready to in_ready
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid & in_ready;
  assign fire      = main_valid_q & out_ready;

  // Buffer next state; flush beats both accept and fire, data only moves on accept or skid drain
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fire) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no accept can coincide with the drain
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = dec_entry;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end
    end
  end

  // State registers; reset also zeroes the data so every output reads 0 while in reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign alu_a          = main_q.a;
  assign alu_b          = main_q.b;
  assign alu_func7      = main_q.func7;
  assign alu_funct3     = main_q.funct3;
  assign alu_op         = main_q.op;
  assign out_pc         = main_q.pc;
  assign out_imm        = main_q.imm;
  assign out_rs2_val    = main_q.rs2_val;
  assign out_rd         = main_q.rd;
  assign out_mem_funct3 = main_q.mem_funct3;
  assign out_illegal    = main_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed cases plus random traffic against a queue-based model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        f7;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  mf3;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_func7;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_op;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [31:0] out_rs2_val;
  logic [4:0]  out_rd;
  logic [2:0]  out_mem_funct3;
  logic        out_illegal;

  int   n_vec;
  int   n_err;
  exp_t q[$];

  id_ex_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .in_rs1_val     (in_rs1_val),
    .in_rs2_val     (in_rs2_val),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_func7      (alu_func7),
    .alu_funct3     (alu_funct3),
    .alu_op         (alu_op),
    .out_pc         (out_pc),
    .out_imm        (out_imm),
    .out_rs2_val    (out_rs2_val),
    .out_rd         (out_rd),
    .out_mem_funct3 (out_mem_funct3),
    .out_illegal    (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the ISA field definitions, using plain shifts and masks
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t        e;
    int signed   s;
    int unsigned opc;
    int unsigned f3;
    logic [31:0] ii, is, ib, iu, ij;
    s   = $signed(ins);
    opc = ins % 128;
    f3  = (ins >> 12) % 8;
    ii  = 32'(s >>> 20);
    is  = 32'((s >>> 25) << 5) | ((ins >> 7) & 32'h1f);
    ib  = 32'((s >>> 31) << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3f) << 5)
          | (((ins >> 8) & 32'hf) << 1);
    iu  = ins & 32'hfffff000;
    ij  = 32'((s >>> 31) << 20) | (ins & 32'h000ff000) | (((ins >> 20) & 32'h1) << 11)
          | (((ins >> 21) & 32'h3ff) << 1);
    e     = '0;
    e.op  = 7'(opc);
    e.pc  = pc;
    e.rs2 = rs2;
    e.rd  = 5'((ins >> 7) % 32);
    e.mf3 = 3'(f3);
    case (opc)
      'h33: begin e.a = rs1; e.b = rs2; e.f7 = 1'((ins >> 30) & 1); e.f3 = 3'(f3); end
      'h13: begin
        e.a = rs1; e.b = ii; e.imm = ii; e.f3 = 3'(f3);
        e.f7 = (f3 == 5) ? 1'((ins >> 30) & 1) : 1'b0;
      end
      'h63: begin e.a = rs1; e.b = rs2; e.f3 = 3'(f3); e.imm = ib; end
      'h37: begin e.a = 0; e.b = iu; e.imm = iu; end
      'h17: begin e.a = pc; e.b = iu; e.imm = iu; end
      'h6f: begin e.a = pc; e.b = 4; e.imm = ij; end
      'h67: begin e.a = pc; e.b = 4; e.imm = ii; end
      'h03: begin e.a = rs1; e.b = ii; e.imm = ii; end
      'h23: begin e.a = rs1; e.b = is; e.imm = is; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Model occupancy: in_ready while fewer than two held, out_valid while any held
  task automatic update_model();
    bit acc;
    bit fir;
    acc = in_valid && (q.size() < 2);
    fir = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (fir) void'(q.pop_front());
      if (acc) q.push_back(ref_decode(in_instr, in_pc, in_rs1_val, in_rs2_val));
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("alu_a", alu_a, q[0].a);
      chk("alu_b", alu_b, q[0].b);
      chk("alu_func7", 32'(alu_func7), 32'(q[0].f7));
      chk("alu_funct3", 32'(alu_funct3), 32'(q[0].f3));
      chk("alu_op", 32'(alu_op), 32'(q[0].op));
      chk("out_pc", out_pc, q[0].pc);
      chk("out_imm", out_imm, q[0].imm);
      chk("out_rs2_val", out_rs2_val, q[0].rs2);
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_mem_funct3", 32'(out_mem_funct3), 32'(q[0].mf3));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_fields"}, {alu_func7, alu_funct3, out_rd, out_mem_funct3, out_illegal}, 32'd0);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
    chk({tag, "_out_imm"}, out_imm, 32'd0);
    chk({tag, "_out_rs2_val"}, out_rs2_val, 32'd0);
  endtask

  // Advance one clock: model follows the inputs seen at the edge, outputs checked at negedge
  task automatic step();
    @(posedge clk);
    update_model();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid   = v;
    in_instr   = ins;
    in_pc      = pc;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
  endtask

  logic [6:0] opcs [10];

  initial begin
    logic [31:0] r;
    n_vec = 0;
    n_err = 0;
    opcs = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h7f};
    resetn = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    step();

    // SUB x0,x1,x2
    out_ready = 1'b1;
    drive(1'b1, 32'h40208033, 32'h0, 32'd7, 32'd3);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_a", alu_a, 32'd7);
    chk("sub_b", alu_b, 32'd3);
    chk("sub_f7", 32'(alu_func7), 32'd1);
    chk("sub_f3", 32'(alu_funct3), 32'd0);
    chk("sub_op", 32'(alu_op), 32'h33);

    // ADDI x1,x0,-1 then SRAI
    drive(1'b1, 32'hFFF00093, 32'h4, 32'd0, 32'd0);
    step();
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    chk("addi_f7", 32'(alu_func7), 32'd0);
    drive(1'b1, 32'h4010D093, 32'h8, 32'h80000000, 32'd0);
    step();
    chk("srai_f7", 32'(alu_func7), 32'd1);
    chk("srai_f3", 32'(alu_funct3), 32'd5);
    chk("srai_b40", 32'(alu_b[4:0]), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();

    // Backpressure: three back-to-back, only two fit
    out_ready = 1'b0;
    drive(1'b1, 32'h00208133, 32'h10, 32'd1, 32'd2);
    step();
    drive(1'b1, 32'h00310193, 32'h14, 32'd5, 32'd0);
    step();
    drive(1'b1, 32'h00000237, 32'h18, 32'd0, 32'd0);
    chk("bp_third_ready", 32'(in_ready), 32'd0);
    step();
    step();
    chk("bp_hold_pc", out_pc, 32'h10);
    out_ready = 1'b1;
    step();
    chk("bp_second_pc", out_pc, 32'h14);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("bp_third_pc", out_pc, 32'h18);
    step();

    // Flush with both entries full and a new instruction offered
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00513, 32'h20, 32'd0, 32'd0);
    step();
    drive(1'b1, 32'h00B00593, 32'h24, 32'd0, 32'd0);
    step();
    drive(1'b1, 32'h00C00613, 32'h28, 32'd0, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // AUIPC, JAL, illegal opcode
    drive(1'b1, 32'h00001017, 32'h100, 32'd9, 32'd9);
    step();
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h1000);
    chk("auipc_f3", 32'(alu_funct3), 32'd0);
    drive(1'b1, 32'h0080006F, 32'h200, 32'd9, 32'd9);
    step();
    chk("jal_a", alu_a, 32'h200);
    chk("jal_b", alu_b, 32'd4);
    drive(1'b1, 32'h0000007F, 32'h300, 32'd9, 32'd9);
    step();
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_ab", alu_a | alu_b, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();

    // Random traffic with random backpressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      if ($urandom_range(0, 7) == 0) in_instr = r;
      else in_instr = {r[31:7], opcs[$urandom_range(0, 9)]};
      in_valid   = ($urandom_range(0, 3) != 0);
      in_pc      = $urandom();
      in_rs1_val = $urandom();
      in_rs2_val = $urandom();
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive(1'b1, 32'h0000007F, 32'h400, 32'd1, 32'd2);
    repeat (3) step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2 resetn = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_zero("post_rst");
    out_ready = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
